gp_register_file: RTL and testbench

GP_REGISTER_FILE -- requirements
Module: gp_register_file

---
 rtl/gp_register_file.sv | 118 +++++++++++
 tb/tb_gp_register_file.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gp_register_file.sv
// General-purpose register file: one write port with load/inc/dec/clear modes,
// two combinational read ports with optional write forwarding, sticky dirty flags.
module gp_register_file #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0,
  localparam int AW       = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [1:0]          wr_mode,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [AW-1:0]       rd_addr_a,
  input  logic [AW-1:0]       rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic [NUM_REGS-1:0] dirty,
  input  logic                dirty_clr,
  output logic                last_wr_zero
);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_CLR  = 2'b11
  } wr_mode_e;

  localparam logic [AW:0] NREGS = (AW + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic                lwz_q, lwz_d;

  logic                wr_acc;
  logic [DATA_W-1:0]   wr_cur;
  logic [DATA_W-1:0]   wr_next;

  // Gating with rstn keeps the forwarding path quiet while reset is held.
  always_comb begin
    wr_acc = rstn && wr_en && ({1'b0, wr_addr} < NREGS)
             && !((ZERO_REG0 != 0) && (wr_addr == '0));
  end

  always_comb begin
    wr_cur = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == AW'(i)) wr_cur = regs_q[i];
    end
  end

  always_comb begin
    wr_next = '0;
    unique case (wr_mode_e'(wr_mode))
      MODE_LOAD: wr_next = wr_data;
      MODE_INC:  wr_next = wr_cur + DATA_W'(1);
      MODE_DEC:  wr_next = wr_cur - DATA_W'(1);
      MODE_CLR:  wr_next = '0;
      default:   wr_next = '0;
    endcase
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((addr == AW'(i)) && !((ZERO_REG0 != 0) && (i == 0))) val = regs_q[i];
    end
    if ((BYPASS != 0) && wr_acc && (addr == wr_addr)) val = wr_next;
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    dirty_d = dirty_clr ? '0 : dirty_q;
    lwz_d   = lwz_q;
    if (wr_acc) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == AW'(i)) begin
          regs_d[i]  = wr_next;
          dirty_d[i] = 1'b1;
        end
      end
      lwz_d = (wr_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
      lwz_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dirty_q <= dirty_d;
      lwz_q   <= lwz_d;
    end
  end

  assign dirty        = dirty_q;
  assign last_wr_zero = lwz_q;

endmodule

// File: tb/tb_gp_register_file.sv
// Scoreboard bench: four configurations share one random stimulus stream and are
// compared against an array-based reference model of the register file.
module tb_gp_register_file;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_mode = 2'b00;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [2:0] rd_a = 3'd0;
  logic [2:0] rd_b = 3'd0;
  logic       dirty_clr = 1'b0;

  logic [7:0] rda [4];
  logic [7:0] rdb [4];
  logic       lwz [4];
  logic [7:0] dty0, dty1, dty2;
  logic [5:0] dty3;

  int nregs [4] = '{8, 8, 8, 6};
  bit byp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit z0    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [7:0] mem    [4][8];
  logic [7:0] mdirty [4];
  logic       mlwz   [4];

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       z;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gp_register_file #(.DATA_W(8), .NUM_REGS(8), .BYPASS(1), .ZERO_REG0(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_data_a(rda[0]),
    .rd_data_b(rdb[0]), .dirty(dty0), .dirty_clr(dirty_clr), .last_wr_zero(lwz[0]));
  gp_register_file #(.DATA_W(8), .NUM_REGS(8), .BYPASS(0), .ZERO_REG0(0)) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_data_a(rda[1]),
    .rd_data_b(rdb[1]), .dirty(dty1), .dirty_clr(dirty_clr), .last_wr_zero(lwz[1]));
  gp_register_file #(.DATA_W(8), .NUM_REGS(8), .BYPASS(1), .ZERO_REG0(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_data_a(rda[2]),
    .rd_data_b(rdb[2]), .dirty(dty2), .dirty_clr(dirty_clr), .last_wr_zero(lwz[2]));
  gp_register_file #(.DATA_W(8), .NUM_REGS(6), .BYPASS(1), .ZERO_REG0(0)) u_dut3 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_data_a(rda[3]),
    .rd_data_b(rdb[3]), .dirty(dty3), .dirty_clr(dirty_clr), .last_wr_zero(lwz[3]));

  function automatic logic [7:0] get_dirty(input int c);
    case (c)
      0:       return dty0;
      1:       return dty1;
      2:       return dty2;
      default: return {2'b00, dty3};
    endcase
  endfunction

  // Reference model: what each configuration should do with the inputs now applied.
  function automatic bit m_acc(input int c);
    return rstn && wr_en && (int'(wr_addr) < nregs[c]) && !(z0[c] && wr_addr == 3'd0);
  endfunction

  function automatic logic [7:0] m_next(input int c);
    case (wr_mode)
      2'b00:   return wr_data;
      2'b01:   return mem[c][wr_addr] + 8'd1;
      2'b10:   return mem[c][wr_addr] - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input int c, input logic [2:0] a);
    if (int'(a) >= nregs[c]) return 8'h00;
    if (z0[c] && a == 3'd0) return 8'h00;
    if (byp[c] && m_acc(c) && a == wr_addr) return m_next(c);
    return mem[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) mem[c][r] = 8'h00;
      mdirty[c] = 8'h00;
      mlwz[c]   = 1'b0;
    end
  endtask

  task automatic cycle(input logic en, input logic [1:0] mode, input logic [2:0] wa,
                       input logic [7:0] wd, input logic [2:0] a, input logic [2:0] b,
                       input logic clr, input logic rn);
    exp_t e;
    logic [7:0] nx;
    @(negedge clk);
    rstn = rn; wr_en = en; wr_mode = mode; wr_addr = wa; wr_data = wd;
    rd_a = a; rd_b = b; dirty_clr = clr;
    for (int c = 0; c < 4; c++) begin
      e.c = c; e.a = m_read(c, a); e.b = m_read(c, b); e.d = mdirty[c]; e.z = mlwz[c];
      sb.push_back(e);
    end
    for (int c = 0; c < 4; c++) begin
      if (rn) begin
        nx = m_next(c);
        if (clr) mdirty[c] = 8'h00;
        if (m_acc(c)) begin
          mem[c][wa]    = nx;
          mdirty[c][wa] = 1'b1;
          mlwz[c]       = (nx == 8'h00);
        end
      end
    end
  endtask

  // Reset dropped 2 ns after a rising edge, held for n cycles of random write traffic.
  task automatic reset_pulse(input int n, input logic [2:0] a);
    @(posedge clk);
    #2 rstn = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom),
            a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic check(input string name, input int c, input logic [7:0] act,
                       input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cfg%0d @%0t: got %h expected %h", name, c, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd_data_a", e.c, rda[e.c], e.a);
        check("rd_data_b", e.c, rdb[e.c], e.b);
        check("dirty", e.c, get_dirty(e.c), e.d);
        check("last_wr_zero", e.c, {7'd0, lwz[e.c]}, {7'd0, e.z});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0] wd;
    logic [2:0] wa;
    model_reset();
    cycle(1'b1, 2'b00, 3'd3, 8'h77, 3'd3, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd1, 3'd2, 1'b1, 1'b0);
    // load/read same register on both ports
    cycle(1'b1, 2'b00, 3'd3, 8'hA5, 3'd3, 3'd3, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0, 1'b1);
    // wrap on increment and decrement
    cycle(1'b1, 2'b00, 3'd5, 8'hFF, 3'd5, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 3'd5, 8'h00, 3'd5, 3'd5, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd5, 3'd4, 1'b0, 1'b1);
    cycle(1'b1, 2'b10, 3'd5, 8'h00, 3'd5, 3'd5, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd5, 3'd5, 1'b0, 1'b1);
    // forwarding vs. registered read
    cycle(1'b1, 2'b00, 3'd2, 8'h3C, 3'd2, 3'd1, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd2, 3'd2, 1'b0, 1'b1);
    // dirty clear coinciding with a write
    cycle(1'b1, 2'b00, 3'd1, 8'h11, 3'd1, 3'd6, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 3'd6, 8'h66, 3'd1, 3'd6, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 3'd4, 8'h44, 3'd4, 3'd6, 1'b1, 1'b1);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd4, 3'd1, 1'b0, 1'b1);
    // register 0 writes and out-of-range addresses
    cycle(1'b1, 2'b00, 3'd0, 8'h55, 3'd0, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 2'b00, 3'd7, 8'h12, 3'd0, 3'd7, 1'b0, 1'b1);
    cycle(1'b1, 2'b11, 3'd6, 8'h00, 3'd6, 3'd7, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0, 1'b1);
    // asynchronous reset mid-operation
    reset_pulse(3, 3'd7);
    cycle(1'b0, 2'b00, 3'd0, 8'h00, 3'd7, 3'd3, 1'b0, 1'b1);
    // randomized traffic with corner-biased data and occasional resets
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 5))
        0:       wd = 8'h00;
        1:       wd = 8'hFF;
        2:       wd = 8'h01;
        default: wd = 8'($urandom);
      endcase
      wa = 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), wa, wd,
            ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) == 0), 1'b1);
      if ($urandom_range(0, 99) == 0) reset_pulse(2, wa);
    end
    @(negedge clk);
    #5;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
